// File: rtl/sweep_wave_gen.sv
// Multi-mode DAC waveform source: square (with optional half-period sweep), sawtooth,
// triangle (compiled in with WAVE_TRIANGLE_EN) and idle code, on a divided DA_Clock.
module sweep_wave_gen #(
  parameter int Data_Width        = 14,
  parameter int DA_Clock_Half_Div = 3,
  parameter int Max_Half_Period   = 5400,
  parameter int Min_Half_Period   = 54,
  parameter int Period_Step       = 54,
  parameter int Dwell             = 10000,
  parameter int Low_Code          = 0,
  parameter int High_Code         = 16383,
  parameter int Ramp_Step         = 2,
  parameter int Idle_Code         = 8192
) (
  input  logic                  Sys_Clock,
  input  logic                  nReset,
  input  logic                  Enable,
  input  logic [1:0]            Mode,
  input  logic                  Sweep,
  output logic                  DA_Clock,
  output logic [Data_Width-1:0] DA_Data,
  output logic                  Sweep_Wrap
);
  localparam int CW  = (DA_Clock_Half_Div > 1) ? $clog2(DA_Clock_Half_Div) : 1;
  localparam int PW  = $clog2(Max_Half_Period + 1);
  localparam int PW1 = PW + 1;
  localparam int LW  = (Dwell > 1) ? $clog2(Dwell) : 1;
  localparam int RW  = Data_Width;
  localparam int RW1 = RW + 1;

  localparam logic [CW-1:0]  DIV_LAST   = CW'(DA_Clock_Half_Div - 1);
  localparam logic [PW-1:0]  MAX_HP     = PW'(Max_Half_Period);
  localparam logic [PW-1:0]  STEP_P     = PW'(Period_Step);
  localparam logic [PW:0]    MIN1       = PW1'(Min_Half_Period);
  localparam logic [PW:0]    STEP1      = PW1'(Period_Step);
  localparam logic [LW-1:0]  DWELL_LAST = LW'(Dwell - 1);
  localparam logic [RW-1:0]  LOW_C      = RW'(Low_Code);
  localparam logic [RW-1:0]  HIGH_C     = RW'(High_Code);
  localparam logic [RW-1:0]  IDLE_C     = RW'(Idle_Code);
  localparam logic [RW:0]    LOW1       = RW1'(Low_Code);
  localparam logic [RW:0]    HIGH1      = RW1'(High_Code);
  localparam logic [RW:0]    RSTEP1     = RW1'(Ramp_Step);

  typedef enum logic [1:0] {
    M_SQUARE = 2'b00,
    M_SAW    = 2'b01,
    M_TRI    = 2'b10,
    M_IDLE   = 2'b11
  } mode_e;

  logic [CW-1:0] div_q, div_d;
  logic          clk_q, clk_d;
  logic [PW-1:0] hp_cnt_q, hp_cnt_d, active_q, active_d, target_q, target_d;
  logic          phase_q, phase_d;
  logic [LW-1:0] dwell_q, dwell_d;
  logic [RW-1:0] ramp_q, ramp_d, data_q, data_d;
  logic [RW:0]   ramp_sum;
  logic          wrap_q, wrap_d;
  mode_e         mode_q, mode_d;
  logic          tick;
`ifdef WAVE_TRIANGLE_EN
  logic          dir_q, dir_d;   // 0 = ramping up
`endif

  // a sample tick is the cycle in which DA_Clock falls
  assign tick = (div_q == DIV_LAST) && clk_q;

  always_comb begin
    div_d    = div_q;
    clk_d    = clk_q;
    hp_cnt_d = hp_cnt_q;
    phase_d  = phase_q;
    dwell_d  = dwell_q;
    ramp_d   = ramp_q;
    active_d = active_q;
    target_d = target_q;
    mode_d   = mode_q;
    data_d   = data_q;
    wrap_d   = 1'b0;
    ramp_sum = '0;
`ifdef WAVE_TRIANGLE_EN
    dir_d    = dir_q;
`endif
    if (div_q == DIV_LAST) begin
      div_d = '0;
      clk_d = ~clk_q;
    end else begin
      div_d = div_q + CW'(1);
    end

    if (tick) begin
      mode_d = mode_e'(Mode);
      // a mode change restarts the waveform; this tick already plays the new mode
      if (mode_d != mode_q) begin
        hp_cnt_d = '0;
        phase_d  = 1'b0;
        ramp_d   = LOW_C;
        dwell_d  = '0;
        active_d = target_q;
`ifdef WAVE_TRIANGLE_EN
        dir_d    = 1'b0;
`endif
      end
      ramp_sum = {1'b0, ramp_d} + RSTEP1;
      case (mode_d)
        M_SQUARE: begin
          data_d = phase_d ? HIGH_C : LOW_C;
          if (hp_cnt_d == active_d - PW'(1)) begin
            phase_d  = ~phase_d;
            hp_cnt_d = '0;
            active_d = target_q;
          end else begin
            hp_cnt_d = hp_cnt_d + PW'(1);
          end
          if (Sweep) begin
            if (dwell_d == DWELL_LAST) begin
              dwell_d = '0;
              if ({1'b0, target_q} < MIN1 + STEP1) begin
                target_d = MAX_HP;
                wrap_d   = 1'b1;
              end else begin
                target_d = target_q - STEP_P;
              end
            end else begin
              dwell_d = dwell_d + LW'(1);
            end
          end
        end
        M_SAW: begin
          data_d = ramp_d;
          if (ramp_sum > HIGH1) ramp_d = LOW_C;
          else                  ramp_d = ramp_sum[RW-1:0];
        end
`ifdef WAVE_TRIANGLE_EN
        M_TRI: begin
          data_d = ramp_d;
          if (!dir_d) begin
            if (ramp_sum >= HIGH1) begin
              ramp_d = HIGH_C;
              dir_d  = 1'b1;
            end else begin
              ramp_d = ramp_sum[RW-1:0];
            end
          end else begin
            if ({1'b0, ramp_d} < LOW1 + RSTEP1) begin
              ramp_d = LOW_C;
              dir_d  = 1'b0;
            end else begin
              ramp_d = ramp_d - RSTEP1[RW-1:0];
            end
          end
        end
`endif
        default: data_d = IDLE_C;
      endcase
    end

    // disabled: hold everything at its reset value
    if (!Enable) begin
      div_d    = '0;
      clk_d    = 1'b0;
      hp_cnt_d = '0;
      phase_d  = 1'b0;
      dwell_d  = '0;
      ramp_d   = LOW_C;
      active_d = MAX_HP;
      target_d = MAX_HP;
      mode_d   = M_IDLE;
      data_d   = IDLE_C;
      wrap_d   = 1'b0;
`ifdef WAVE_TRIANGLE_EN
      dir_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge Sys_Clock or negedge nReset) begin
    if (!nReset) begin
      div_q    <= '0;
      clk_q    <= 1'b0;
      hp_cnt_q <= '0;
      phase_q  <= 1'b0;
      dwell_q  <= '0;
      ramp_q   <= LOW_C;
      active_q <= MAX_HP;
      target_q <= MAX_HP;
      mode_q   <= M_IDLE;
      data_q   <= IDLE_C;
      wrap_q   <= 1'b0;
`ifdef WAVE_TRIANGLE_EN
      dir_q    <= 1'b0;
`endif
    end else begin
      div_q    <= div_d;
      clk_q    <= clk_d;
      hp_cnt_q <= hp_cnt_d;
      phase_q  <= phase_d;
      dwell_q  <= dwell_d;
      ramp_q   <= ramp_d;
      active_q <= active_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      wrap_q   <= wrap_d;
`ifdef WAVE_TRIANGLE_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign DA_Clock   = clk_q;
  assign DA_Data    = data_q;
  assign Sweep_Wrap = wrap_q;

endmodule

// File: tb/tb_sweep_wave_gen.sv
// Scoreboard bench for sweep_wave_gen: expected samples are queued per scenario and
// compared against DA_Data at every DA_Clock falling edge.
module tb_sweep_wave_gen;
  logic        Sys_Clock = 1'b0;
  logic        nReset, Enable, Sweep;
  logic [1:0]  Mode;
  logic        DA_Clock, Sweep_Wrap;
  logic [13:0] DA_Data;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int ticks_seen = 0;
  int wrap_cnt = 0;
  int first_wrap_at = -1;
  logic prev_clk = 1'b0;

  always #5 Sys_Clock = ~Sys_Clock;

  sweep_wave_gen #(
    .Data_Width(14), .DA_Clock_Half_Div(3), .Max_Half_Period(8), .Min_Half_Period(4),
    .Period_Step(2), .Dwell(32), .Low_Code(0), .High_Code(100), .Ramp_Step(30),
    .Idle_Code(50)
  ) dut (
    .Sys_Clock(Sys_Clock), .nReset(nReset), .Enable(Enable), .Mode(Mode), .Sweep(Sweep),
    .DA_Clock(DA_Clock), .DA_Data(DA_Data), .Sweep_Wrap(Sweep_Wrap)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // monitor: a DA_Clock 1->0 transition marks a sample tick
  always @(negedge Sys_Clock) begin
    int e;
    if (prev_clk && !DA_Clock && nReset) begin
      ticks_seen++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data", int'(DA_Data), e);
      end
    end
    if (Sweep_Wrap) begin
      wrap_cnt++;
      if (wrap_cnt == 1) first_wrap_at = ticks_seen;
    end
    prev_clk = DA_Clock;
  end

  task automatic push_n(input int v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge Sys_Clock); #1;
    end
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // DA_Clock after each of the first 9 edges following enable/reset release
  task automatic chk_clk(input string tag);
    int pat[9];
    pat = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
    for (int i = 0; i < 9; i++) begin
      @(negedge Sys_Clock);
      chk(tag, int'(DA_Clock), pat[i]);
    end
  endtask

  task automatic wait_clk_hi();
    for (int i = 0; i < 20; i++) begin
      if (DA_Clock) break;
      @(negedge Sys_Clock); #1;
    end
    chk("clk_hi", int'(DA_Clock), 1);
  endtask

  task automatic en_reset(input logic [1:0] m, input logic s);
    @(negedge Sys_Clock); #1;
    Enable = 1'b0;
    @(negedge Sys_Clock); #1;
    Mode = m; Sweep = s; Enable = 1'b1;
  endtask

  function automatic int tgt(input int t);
    case ((t / 32) % 3)
      0:       return 8;
      1:       return 6;
      default: return 4;
    endcase
  endfunction

  initial begin
    int half, cnt;
    bit ph;
    nReset = 1'b0; Enable = 1'b0; Mode = 2'b00; Sweep = 1'b0;
    #12;
    chk("rst_clk", int'(DA_Clock), 0);
    chk("rst_data", int'(DA_Data), 50);
    chk("rst_wrap", int'(Sweep_Wrap), 0);

    // plain square: 8 samples per level
    @(negedge Sys_Clock); #1;
    push_n(0, 8); push_n(100, 8); push_n(0, 8); push_n(100, 8);
    nReset = 1'b1; Enable = 1'b1;
    chk_clk("clk_start");
    drain(400);

    // swept square: half periods 8,6,4 with 32-tick dwell, applied at level edges
    en_reset(2'b00, 1'b1);
    ticks_seen = 0; wrap_cnt = 0; first_wrap_at = -1;
    half = 8; cnt = 0; ph = 1'b0;
    for (int t = 0; t < 200; t++) begin
      exp_q.push_back(ph ? 100 : 0);
      if (cnt == half - 1) begin
        ph = ~ph; cnt = 0; half = tgt(t);
      end else begin
        cnt++;
      end
    end
    drain(1500);
    chk("wrap_cnt", wrap_cnt, 2);
    chk("wrap_at", first_wrap_at, 96);

    // sawtooth
    en_reset(2'b01, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push_n(0, 1); push_n(30, 1); push_n(60, 1); push_n(90, 1);
    end
    drain(200);

    // triangle or idle depending on build
    en_reset(2'b10, 1'b0);
`ifdef WAVE_TRIANGLE_EN
    for (int k = 0; k < 2; k++) begin
      push_n(0, 1); push_n(30, 1); push_n(60, 1); push_n(90, 1);
      push_n(100, 1); push_n(70, 1); push_n(40, 1); push_n(10, 1);
    end
    push_n(0, 1); push_n(30, 1);
`else
    push_n(50, 10);
`endif
    drain(200);

    // mode change in the middle of a high level restarts the ramp
    en_reset(2'b00, 1'b0);
    push_n(0, 8); push_n(100, 3);
    drain(200);
    Mode = 2'b01;
    push_n(0, 1); push_n(30, 1); push_n(60, 1);
    drain(100);

    // dropping Enable returns outputs to idle after one edge
    wait_clk_hi();
    Enable = 1'b0;
    @(negedge Sys_Clock); #1;
    chk("dis_clk", int'(DA_Clock), 0);
    chk("dis_data", int'(DA_Data), 50);
    chk("dis_wrap", int'(Sweep_Wrap), 0);

    // asynchronous reset mid-run, then a clean restart
    Mode = 2'b00; Sweep = 1'b0;
    @(negedge Sys_Clock); #1;
    Enable = 1'b1;
    push_n(0, 8); push_n(100, 2);
    drain(200);
    wait_clk_hi();
    #2 nReset = 1'b0;
    #1;
    chk("arst_clk", int'(DA_Clock), 0);
    chk("arst_data", int'(DA_Data), 50);
    chk("arst_wrap", int'(Sweep_Wrap), 0);
    @(negedge Sys_Clock); #1;
    push_n(0, 8); push_n(100, 8); push_n(0, 8); push_n(100, 8);
    nReset = 1'b1;
    chk_clk("clk_restart");
    drain(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
